// File: rtl/uart_pkg.sv
// Shared types and limits for the UART receive-side controller.
package uart_pkg;
    localparam int FRAME_W = 9;
    localparam int BAUD_W  = 3;
    localparam int LEN_W   = 4;
    localparam logic [LEN_W-1:0] LEN_MIN = 4'd5;
    localparam logic [LEN_W-1:0] LEN_MAX = 4'd9;

    typedef enum logic [1:0] {RUN, DRAIN, APPLY, SETTLE} state_t;

    // A 9-bit frame leaves no room for a parity bit.
    function automatic logic cfg_ok(input logic [LEN_W-1:0] len, input logic par);
        return (len >= LEN_MIN) && (len <= LEN_MAX) && !((len == LEN_MAX) && par);
    endfunction
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host configuration port and frame output stream of uart_rx_ctrl.
interface uart_rx_ctrl_if;
    import uart_pkg::*;

    logic                cfg_wr;
    logic [BAUD_W-1:0]   cfg_baud;
    logic                cfg_parity;
    logic                cfg_parity_type;
    logic                cfg_stop_bits;
    logic [LEN_W-1:0]    cfg_len;
    logic                cfg_busy;
    logic                cfg_done;
    logic                cfg_err;
    // Output stream: a frame transfers on every clk edge where dout_valid and
    // dout_ready are both high; dout holds steady while dout_valid waits for ready.
    logic [FRAME_W-1:0]  dout;
    logic                dout_valid;
    logic                dout_ready;
    logic                overflow;
    logic                ovf_clr;

    modport master (
        output cfg_wr, cfg_baud, cfg_parity, cfg_parity_type, cfg_stop_bits, cfg_len,
        output dout_ready, ovf_clr,
        input  cfg_busy, cfg_done, cfg_err, dout, dout_valid, overflow
    );

    modport slave (
        input  cfg_wr, cfg_baud, cfg_parity, cfg_parity_type, cfg_stop_bits, cfg_len,
        input  dout_ready, ovf_clr,
        output cfg_busy, cfg_done, cfg_err, dout, dout_valid, overflow
    );
endinterface

// File: rtl/uart_frame_fifo.sv
// Small frame FIFO with a registered head, valid/ready output and a sticky drop flag.
module uart_frame_fifo import uart_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [FRAME_W-1:0] din,
    output logic [FRAME_W-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               overflow,
    input  logic               ovf_clr
);
    localparam int AW = $clog2(DEPTH);

    logic [FRAME_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]        count, count_nxt;
    logic               full, pop, wr_en, drop;

    assign full       = (count == (AW+1)'(DEPTH));
    assign dout_valid = (count != '0);
    assign pop        = dout_valid && dout_ready;
    assign wr_en      = push && (!full || pop);
    assign drop       = push && full && !pop;
    assign rd_nxt     = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_nxt = count;
        case ({wr_en, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dout     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            // The incoming frame becomes the head when it lands on the next read slot.
            if (count_nxt == '0)
                dout <= '0;
            else if (wr_en && (wr_ptr == rd_nxt))
                dout <= din;
            else
                dout <= mem[rd_nxt];
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-path configuration owner: applies host settings on an idle line and buffers frames.
module uart_rx_ctrl import uart_pkg::*; #(
    parameter int                DEPTH      = 4,
    parameter int                IDLE_CYC   = 160,
    parameter int                SETTLE_CYC = 32,
    parameter logic [BAUD_W-1:0] DEF_BAUD   = 3'd2,
    parameter logic [LEN_W-1:0]  DEF_LEN    = 4'd8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    output logic               rx_out,
    uart_rx_ctrl_if.slave      bus,
    output logic [BAUD_W-1:0]  baud,
    output logic               parity,
    output logic               parity_type,
    output logic               stop_bits,
    output logic [LEN_W-1:0]   frame_length,
    output logic               baud_ready,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid_in,
    output state_t             state
);
    localparam int IDLE_W = $clog2(IDLE_CYC + 1);
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);

    state_t            state_q, state_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic [BAUD_W-1:0] sh_baud;
    logic [LEN_W-1:0]  sh_len;
    logic              sh_par, sh_ptype, sh_stop;
    logic              pending, cfg_busy, cfg_done_q, cfg_err_q;
    logic              wr_ok, wr_bad, settle_end;

    assign wr_ok      = bus.cfg_wr && (state_q == RUN) && cfg_ok(bus.cfg_len, bus.cfg_parity);
    assign wr_bad     = bus.cfg_wr && !wr_ok;
    assign settle_end = (settle_cnt == SET_W'(SETTLE_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= APPLY;
        else      state_q <= state_nxt;
    end

    always_comb begin
        state_nxt  = state_q;
        baud_ready = 1'b1;
        rx_out     = rx_in;
        cfg_busy   = 1'b1;
        case (state_q)
            RUN: begin
                cfg_busy = 1'b0;
                if (wr_ok) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (rx_in && (idle_cnt == IDLE_W'(IDLE_CYC - 1))) state_nxt = APPLY;
            end
            APPLY: begin
                baud_ready = 1'b0;
                rx_out     = 1'b1;
                state_nxt  = SETTLE;
            end
            SETTLE: begin
                rx_out = 1'b1;
                if (settle_end) state_nxt = RUN;
            end
            default: state_nxt = APPLY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            idle_cnt   <= ((state_q == DRAIN) && rx_in) ? idle_cnt + IDLE_W'(1) : '0;
            settle_cnt <= (state_q == SETTLE) ? settle_cnt + SET_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_baud <= DEF_BAUD;
            sh_len  <= DEF_LEN;
            sh_par  <= 1'b0;
            sh_ptype <= 1'b0;
            sh_stop <= 1'b0;
        end else if (wr_ok) begin
            sh_baud  <= bus.cfg_baud;
            sh_len   <= bus.cfg_len;
            sh_par   <= bus.cfg_parity;
            sh_ptype <= bus.cfg_parity_type;
            sh_stop  <= bus.cfg_stop_bits;
        end
    end

    // Active settings change on entry to APPLY so they are visible while baud_ready is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud         <= DEF_BAUD;
            frame_length <= DEF_LEN;
            parity       <= 1'b0;
            parity_type  <= 1'b0;
            stop_bits    <= 1'b0;
        end else if (state_nxt == APPLY) begin
            baud         <= sh_baud;
            frame_length <= sh_len;
            parity       <= sh_par;
            parity_type  <= sh_ptype;
            stop_bits    <= sh_stop;
        end
    end

    // pending separates a host-driven change from the post-reset bring-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= 1'b0;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q  <= wr_bad;
            cfg_done_q <= (state_q == SETTLE) && settle_end && pending;
            if (wr_ok)
                pending <= 1'b1;
            else if ((state_q == SETTLE) && settle_end)
                pending <= 1'b0;
        end
    end

    assign bus.cfg_busy = cfg_busy;
    assign bus.cfg_done = cfg_done_q;
    assign bus.cfg_err  = cfg_err_q;
    assign state        = state_q;

    uart_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push       (frame_valid_in),
        .din        (frame_in),
        .dout       (bus.dout),
        .dout_valid (bus.dout_valid),
        .dout_ready (bus.dout_ready),
        .overflow   (bus.overflow),
        .ovf_clr    (bus.ovf_clr)
    );
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scenario bench for uart_rx_ctrl: bring-up, reconfiguration, rejects, FIFO behaviour, reset.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DEPTH      = 4;
  localparam int IDLE_CYC   = 160;
  localparam int SETTLE_CYC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_in;
  logic        rx_out;
  logic [2:0]  baud;
  logic        parity, parity_type, stop_bits;
  logic [3:0]  frame_length;
  logic        baud_ready;
  logic [8:0]  frame_in;
  logic        frame_valid_in;
  state_t      state;

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_CYC(IDLE_CYC), .SETTLE_CYC(SETTLE_CYC),
                 .DEF_BAUD(3'd2), .DEF_LEN(4'd8)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_in          (rx_in),
    .rx_out         (rx_out),
    .bus            (bus),
    .baud           (baud),
    .parity         (parity),
    .parity_type    (parity_type),
    .stop_bits      (stop_bits),
    .frame_length   (frame_length),
    .baud_ready     (baud_ready),
    .frame_in       (frame_in),
    .frame_valid_in (frame_valid_in),
    .state          (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];
  int model_cnt = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] b, input logic [3:0] len, input logic par);
    bus.cfg_wr = 1'b1; bus.cfg_baud = b; bus.cfg_len = len;
    bus.cfg_parity = par; bus.cfg_parity_type = 1'b0; bus.cfg_stop_bits = 1'b0;
    tick();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic push_frame(input logic [8:0] v);
    frame_in = v; frame_valid_in = 1'b1;
    if (model_cnt < DEPTH) begin
      exp_q.push_back(v);
      model_cnt++;
    end
    tick();
    frame_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (state !== APPLY) begin n_bad++; $display("FAIL rst_state: got %0d want %0d", state, APPLY); end
    n_cmp++; if (baud_ready !== 1'b0 || rx_out !== 1'b1 || bus.cfg_busy !== 1'b1) begin
      n_bad++; $display("FAIL rst_ctrl: baud_ready=%b rx_out=%b busy=%b want 0/1/1", baud_ready, rx_out, bus.cfg_busy); end
    n_cmp++; if (baud !== 3'd2 || frame_length !== 4'd8 || {parity, parity_type, stop_bits} !== 3'b000) begin
      n_bad++; $display("FAIL rst_cfg: baud=%0d len=%0d pps=%b want 2/8/000", baud, frame_length, {parity, parity_type, stop_bits}); end
    n_cmp++; if (bus.dout_valid !== 1'b0 || bus.dout !== 9'h000 || bus.overflow !== 1'b0 ||
                 bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_fifo: valid=%b dout=%h ovf=%b done=%b err=%b want all 0",
                        bus.dout_valid, bus.dout, bus.overflow, bus.cfg_done, bus.cfg_err); end
    rst = 1'b1;
    n_cmp++; if (baud_ready !== 1'b0) begin n_bad++; $display("FAIL bringup_apply: baud_ready=%b want 0", baud_ready); end
    for (int i = 0; i < SETTLE_CYC; i++) begin
      tick();
      n_cmp++; if (baud_ready !== 1'b1 || rx_out !== 1'b1 || bus.cfg_done !== 1'b0) begin
        n_bad++; $display("FAIL bringup_settle_%0d: baud_ready=%b rx_out=%b done=%b want 1/1/0", i, baud_ready, rx_out, bus.cfg_done); end
    end
    tick();
    n_cmp++; if (state !== RUN || bus.cfg_busy !== 1'b0 || bus.cfg_done !== 1'b0) begin
      n_bad++; $display("FAIL bringup_run: state=%0d busy=%b done=%b want RUN/0/0", state, bus.cfg_busy, bus.cfg_done); end
    n_cmp++; if (rx_out !== rx_in || baud !== 3'd2 || frame_length !== 4'd8) begin
      n_bad++; $display("FAIL bringup_cfg: rx_out=%b rx_in=%b baud=%0d len=%0d want pass/2/8", rx_out, rx_in, baud, frame_length); end
  endtask

  task automatic test_reconfig();
    int hit;
    cfg_write(3'd3, 4'd7, 1'b1);
    n_cmp++; if (state !== DRAIN || bus.cfg_busy !== 1'b1 || bus.cfg_err !== 1'b0 || baud !== 3'd2) begin
      n_bad++; $display("FAIL reconf_drain: state=%0d busy=%b err=%b baud=%0d want DRAIN/1/0/2", state, bus.cfg_busy, bus.cfg_err, baud); end
    for (int i = 0; i < 240; i++) begin
      rx_in = (i % 40 == 39) ? 1'b0 : 1'(($urandom_range(0, 1)));
      tick();
      n_cmp++; if (state !== DRAIN || rx_out !== rx_in) begin
        n_bad++; $display("FAIL reconf_toggle_%0d: state=%0d rx_out=%b rx_in=%b want DRAIN/follow", i, state, rx_out, rx_in); end
    end
    rx_in = 1'b0; tick();
    rx_in = 1'b1;
    hit = 0;
    for (int i = 1; i <= 200 && hit == 0; i++) begin
      tick();
      if (state === APPLY) hit = i;
    end
    n_cmp++; if (hit != IDLE_CYC) begin n_bad++; $display("FAIL reconf_idle: APPLY after %0d high cycles want %0d", hit, IDLE_CYC); end
    n_cmp++; if (baud_ready !== 1'b0 || rx_out !== 1'b1 || baud !== 3'd3 || frame_length !== 4'd7 || parity !== 1'b1) begin
      n_bad++; $display("FAIL reconf_apply: baud_ready=%b rx_out=%b baud=%0d len=%0d par=%b want 0/1/3/7/1",
                        baud_ready, rx_out, baud, frame_length, parity); end
    rx_in = 1'b0;
    for (int i = 0; i < SETTLE_CYC; i++) begin
      tick();
      n_cmp++; if (state !== SETTLE || baud_ready !== 1'b1 || rx_out !== 1'b1 || bus.cfg_done !== 1'b0) begin
        n_bad++; $display("FAIL reconf_settle_%0d: state=%0d br=%b rx_out=%b done=%b want SETTLE/1/1/0",
                          i, state, baud_ready, rx_out, bus.cfg_done); end
    end
    tick();
    n_cmp++; if (state !== RUN || bus.cfg_done !== 1'b1) begin
      n_bad++; $display("FAIL reconf_done: state=%0d done=%b want RUN/1", state, bus.cfg_done); end
    tick();
    n_cmp++; if (bus.cfg_done !== 1'b0) begin n_bad++; $display("FAIL reconf_done_pulse: done=%b want 0", bus.cfg_done); end
    rx_in = 1'b1;
  endtask

  task automatic test_overflow();
    logic [8:0] vals [5];
    logic [8:0] exp;
    vals[0] = 9'h0A5; vals[1] = 9'h047; vals[2] = 9'h1FF; vals[3] = 9'h000; vals[4] = 9'h123;
    bus.dout_ready = 1'b0;
    push_frame(vals[0]);
    n_cmp++; if (bus.dout_valid !== 1'b1 || bus.dout !== 9'h0A5) begin
      n_bad++; $display("FAIL ovf_first: valid=%b dout=%h want 1/0a5", bus.dout_valid, bus.dout); end
    for (int i = 1; i < 5; i++) push_frame(vals[i]);
    n_cmp++; if (bus.overflow !== 1'b1 || bus.dout !== 9'h0A5) begin
      n_bad++; $display("FAIL ovf_set: ovf=%b dout=%h want 1/0a5", bus.overflow, bus.dout); end
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      exp = exp_q.pop_front(); model_cnt--;
      n_cmp++; if (bus.dout_valid !== 1'b1 || bus.dout !== exp) begin
        n_bad++; $display("FAIL ovf_drain_%0d: valid=%b dout=%h want 1/%h", k, bus.dout_valid, bus.dout, exp); end
      tick();
    end
    bus.dout_ready = 1'b0;
    n_cmp++; if (bus.dout_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: valid=%b want 0", bus.dout_valid); end
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: ovf=%b want 0", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [8:0] exp;
    push_frame(9'h011); push_frame(9'h022); push_frame(9'h033); push_frame(9'h044);
    n_cmp++; if (bus.dout !== exp_q[0] || bus.overflow !== 1'b0) begin
      n_bad++; $display("FAIL full_head: dout=%h ovf=%b want %h/0", bus.dout, bus.overflow, exp_q[0]); end
    frame_in = 9'h155; frame_valid_in = 1'b1; bus.dout_ready = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(9'h155);
    tick();
    frame_valid_in = 1'b0; bus.dout_ready = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b0 || bus.dout_valid !== 1'b1 || bus.dout !== exp_q[0]) begin
      n_bad++; $display("FAIL full_pushpop: ovf=%b valid=%b dout=%h want 0/1/%h", bus.overflow, bus.dout_valid, bus.dout, exp_q[0]); end
    push_frame(9'h0AB);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL full_drop: ovf=%b want 1", bus.overflow); end
    bus.ovf_clr = 1'b1; push_frame(9'h0CD); bus.ovf_clr = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL clr_vs_drop: ovf=%b want 1", bus.overflow); end
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL full_clr: ovf=%b want 0", bus.overflow); end
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      exp = exp_q.pop_front(); model_cnt--;
      n_cmp++; if (bus.dout_valid !== 1'b1 || bus.dout !== exp) begin
        n_bad++; $display("FAIL full_drain_%0d: valid=%b dout=%h want 1/%h", k, bus.dout_valid, bus.dout, exp); end
      tick();
    end
    bus.dout_ready = 1'b0;
    n_cmp++; if (bus.dout_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty: valid=%b want 0", bus.dout_valid); end
  endtask

  task automatic test_cfg_reject();
    rx_in = 1'b0;
    cfg_write(3'd6, 4'd4, 1'b0);
    n_cmp++; if (bus.cfg_err !== 1'b1 || state !== RUN || baud !== 3'd3 || frame_length !== 4'd7) begin
      n_bad++; $display("FAIL rej_len4: err=%b state=%0d baud=%0d len=%0d want 1/RUN/3/7", bus.cfg_err, state, baud, frame_length); end
    tick();
    n_cmp++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL rej_pulse: err=%b want 0", bus.cfg_err); end
    cfg_write(3'd6, 4'd9, 1'b1);
    n_cmp++; if (bus.cfg_err !== 1'b1 || state !== RUN || parity !== 1'b1 || frame_length !== 4'd7) begin
      n_bad++; $display("FAIL rej_len9par: err=%b state=%0d par=%b len=%0d want 1/RUN/1/7", bus.cfg_err, state, parity, frame_length); end
    tick();
    cfg_write(3'd5, 4'd9, 1'b0);
    n_cmp++; if (bus.cfg_err !== 1'b0 || state !== DRAIN) begin
      n_bad++; $display("FAIL rej_len9ok: err=%b state=%0d want 0/DRAIN", bus.cfg_err, state); end
    cfg_write(3'd1, 4'd6, 1'b0);
    n_cmp++; if (bus.cfg_err !== 1'b1 || state !== DRAIN || baud !== 3'd3) begin
      n_bad++; $display("FAIL rej_in_drain: err=%b state=%0d baud=%0d want 1/DRAIN/3", bus.cfg_err, state, baud); end
  endtask

  task automatic test_reset_mid_drain();
    push_frame(9'(($urandom_range(0, 511))));
    push_frame(9'(($urandom_range(0, 511))));
    n_cmp++; if (state !== DRAIN || bus.dout_valid !== 1'b1 || bus.dout !== exp_q[0]) begin
      n_bad++; $display("FAIL mid_queued: state=%0d valid=%b dout=%h want DRAIN/1/%h", state, bus.dout_valid, bus.dout, exp_q[0]); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.dout_valid !== 1'b0 || baud_ready !== 1'b0 || baud !== 3'd2 || state !== APPLY) begin
      n_bad++; $display("FAIL mid_reset: valid=%b br=%b baud=%0d state=%0d want 0/0/2/APPLY", bus.dout_valid, baud_ready, baud, state); end
    exp_q.delete(); model_cnt = 0;
    tick();
    rst = 1'b1;
    rx_in = 1'b1;
    for (int i = 0; i <= SETTLE_CYC; i++) begin
      tick();
      n_cmp++; if (bus.cfg_done !== 1'b0) begin n_bad++; $display("FAIL mid_no_done_%0d: done=%b want 0", i, bus.cfg_done); end
    end
    n_cmp++; if (state !== RUN || baud !== 3'd2 || frame_length !== 4'd8 || parity !== 1'b0) begin
      n_bad++; $display("FAIL mid_defaults: state=%0d baud=%0d len=%0d par=%b want RUN/2/8/0", state, baud, frame_length, parity); end
  endtask

  initial begin
    rst = 1'b0; rx_in = 1'b0;
    bus.cfg_wr = 1'b0; bus.cfg_baud = '0; bus.cfg_parity = 1'b0; bus.cfg_parity_type = 1'b0;
    bus.cfg_stop_bits = 1'b0; bus.cfg_len = '0; bus.dout_ready = 1'b0; bus.ovf_clr = 1'b0;
    frame_in = '0; frame_valid_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_reconfig();
    test_overflow();
    test_full_push_pop();
    test_cfg_reject();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
